asu_ddr5_write_controller: RTL and testbench

Write-path state machine for the DDR5 PHY. It sits directly downstream of the write counters: it consumes their done/decision flags and produces the state-indication signals they count against. It also drives the DQ/DQS output enables for the write datapath. It sequences each write burst through preamble, data, optional PHY-generated CRC, and then either interamble or postamble, with a watchdog that aborts a stuck sequence.

---
 rtl/asu_ddr5_write_controller_if.sv | 39 +++
 rtl/asu_ddr5_write_controller.sv | 132 +++++++++++++
 tb/tb_asu_ddr5_write_controller.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/asu_ddr5_write_controller_if.sv
// Signal bundle between the DDR5 write counters / memory controller and the write-path FSM.
interface asu_ddr5_write_controller_if;
  logic       wr_en_i;
  logic [1:0] burstlength_i;
  logic       crc_generate_i;
  logic       interamble_i;
  logic       preamble_done_i;
  logic       wrdata_done_i;
  logic       wrmask_done_i;
  logic       wrdata_crc_done_i;
  logic       interamble_done_i;
  logic       postamble_done_i;

  logic       preamble_state_o;
  logic       data_state_o;
  logic       interamble_valid_o;
  logic       crc_state_o;
  logic       dqs_oe_o;
  logic       dq_oe_o;
  logic [2:0] state_o;
  logic [7:0] burst_count_o;
  logic       err_o;

  modport master (
    output wr_en_i, burstlength_i, crc_generate_i, interamble_i,
           preamble_done_i, wrdata_done_i, wrmask_done_i,
           wrdata_crc_done_i, interamble_done_i, postamble_done_i,
    input  preamble_state_o, data_state_o, interamble_valid_o, crc_state_o,
           dqs_oe_o, dq_oe_o, state_o, burst_count_o, err_o
  );

  modport slave (
    input  wr_en_i, burstlength_i, crc_generate_i, interamble_i,
           preamble_done_i, wrdata_done_i, wrmask_done_i,
           wrdata_crc_done_i, interamble_done_i, postamble_done_i,
    output preamble_state_o, data_state_o, interamble_valid_o, crc_state_o,
           dqs_oe_o, dq_oe_o, state_o, burst_count_o, err_o
  );
endinterface

// File: rtl/asu_ddr5_write_controller.sv
// DDR5 PHY write-path sequencer: preamble, data, optional CRC, interamble/postamble,
// with a per-state watchdog that aborts to IDLE and latches a sticky error.
//
// state      | meaning
// IDLE       | no write activity, output enables off
// PREAMBLE   | DQS preamble toggling before the first data beat
// WRDATA     | data beats on DQ
// WRDATA_CRC | PHY-generated CRC beats after the data
// INTERAMBLE | gap between chained bursts, DQS kept driven
// POSTAMBLE  | DQS postamble after the last burst
module asu_ddr5_write_controller #(
  parameter int unsigned WDOG_CYCLES = 64
) (
  input logic                        clk_i,
  input logic                        rst_i,
  asu_ddr5_write_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PREAMBLE   = 3'd1,
    S_WRDATA     = 3'd2,
    S_WRDATA_CRC = 3'd3,
    S_INTERAMBLE = 3'd4,
    S_POSTAMBLE  = 3'd5
  } state_t;

  localparam logic [7:0] WDOG_LIM = 8'(WDOG_CYCLES);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_stay;
  logic [7:0] r_burst_count;
  logic       r_err;
  logic       r_preamble_state;
  logic       r_data_state;
  logic       r_interamble_valid;
  logic       r_crc_state;
  logic       r_dqs_oe;
  logic       r_dq_oe;
  logic       w_burst_end;
  logic       w_wdog_hit;
  logic [1:0] w_bl;
  logic       w_unused_bl;

  // Burst length only steers the counters; the FSM sequence is identical for every length.
  assign w_bl        = (bus.burstlength_i == 2'b11) ? 2'b00 : bus.burstlength_i;
  assign w_unused_bl = ^w_bl;

  assign w_wdog_hit = (r_state != S_IDLE) && (r_stay == WDOG_LIM);

  always_comb begin
    w_next      = r_state;
    w_burst_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.wr_en_i) w_next = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        if (bus.preamble_done_i) w_next = S_WRDATA;
      end
      S_WRDATA: begin
        if (bus.crc_generate_i && bus.wrdata_done_i) begin
          w_next = S_WRDATA_CRC;
        end else if (!bus.crc_generate_i && (bus.wrdata_done_i || bus.wrmask_done_i)) begin
          w_burst_end = 1'b1;
          w_next      = bus.interamble_i ? S_INTERAMBLE : S_POSTAMBLE;
        end
      end
      S_WRDATA_CRC: begin
        if (bus.wrdata_crc_done_i) begin
          w_burst_end = 1'b1;
          w_next      = bus.interamble_i ? S_INTERAMBLE : S_POSTAMBLE;
        end
      end
      S_INTERAMBLE: begin
        if (bus.interamble_done_i) w_next = S_WRDATA;
      end
      S_POSTAMBLE: begin
        if (bus.postamble_done_i) w_next = bus.wr_en_i ? S_PREAMBLE : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // The abort beats any done flag sampled on the same edge.
    if (w_wdog_hit) begin
      w_next      = S_IDLE;
      w_burst_end = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state            <= S_IDLE;
      r_stay             <= 8'd0;
      r_burst_count      <= 8'd0;
      r_err              <= 1'b0;
      r_preamble_state   <= 1'b0;
      r_data_state       <= 1'b0;
      r_interamble_valid <= 1'b0;
      r_crc_state        <= 1'b0;
      r_dqs_oe           <= 1'b0;
      r_dq_oe            <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || (w_next == S_IDLE)) begin
        r_stay <= 8'd0;
      end else if (r_stay != 8'hFF) begin
        r_stay <= r_stay + 8'd1;
      end
      if (w_burst_end) r_burst_count <= r_burst_count + 8'd1;
      if (w_wdog_hit)  r_err         <= 1'b1;
      r_preamble_state   <= (w_next == S_PREAMBLE) || (w_next == S_POSTAMBLE) ||
                            (w_next == S_INTERAMBLE);
      r_data_state       <= (w_next == S_WRDATA) || (w_next == S_WRDATA_CRC);
      r_interamble_valid <= (w_next == S_INTERAMBLE);
      r_crc_state        <= (w_next == S_WRDATA_CRC);
      r_dqs_oe           <= (w_next != S_IDLE);
      r_dq_oe            <= (w_next == S_WRDATA) || (w_next == S_WRDATA_CRC);
    end
  end

  assign bus.state_o            = r_state;
  assign bus.burst_count_o      = r_burst_count;
  assign bus.err_o              = r_err;
  assign bus.preamble_state_o   = r_preamble_state;
  assign bus.data_state_o       = r_data_state;
  assign bus.interamble_valid_o = r_interamble_valid;
  assign bus.crc_state_o        = r_crc_state;
  assign bus.dqs_oe_o           = r_dqs_oe;
  assign bus.dq_oe_o            = r_dq_oe;

endmodule

// File: tb/tb_asu_ddr5_write_controller.sv
// Bench for the DDR5 write controller: burst plans are built as timed state segments and
// the expected per-cycle outputs follow directly from each segment's intended state.
module tb_asu_ddr5_write_controller;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_PRE = 3'd1, ST_DATA = 3'd2,
                         ST_CRC = 3'd3, ST_INTER = 3'd4, ST_POST = 3'd5;
  // done bit order: 0 preamble, 1 wrdata, 2 wrmask, 3 wrdata_crc, 4 interamble, 5 postamble
  localparam logic [5:0] D_PRE = 6'b000001, D_WR = 6'b000010, D_MASK = 6'b000100,
                         D_CRC = 6'b001000, D_INT = 6'b010000, D_POST = 6'b100000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  asu_ddr5_write_controller_if bus_main();
  asu_ddr5_write_controller_if bus_wd();

  asu_ddr5_write_controller #(.WDOG_CYCLES(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus_main.slave)
  );
  asu_ddr5_write_controller #(.WDOG_CYCLES(8)) dut_wd (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus_wd.slave)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] bc;
    logic       err;
    logic       wr_en;
    logic       crc;
    logic       inter;
    logic [1:0] bl;
    logic [5:0] done;
  } rec_t;

  rec_t        plan[$];
  logic [17:0] obs[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  m_bc = 8'd0;
  logic        m_err = 1'b0;

  function automatic logic [5:0] relevant(input logic [2:0] st);
    case (st)
      ST_PRE:   return D_PRE;
      ST_DATA:  return D_WR | D_MASK;
      ST_CRC:   return D_CRC;
      ST_INTER: return D_INT;
      ST_POST:  return D_POST;
      default:  return 6'b0;
    endcase
  endfunction

  // {preamble_state, data_state, interamble_valid, crc_state, dqs_oe, dq_oe}
  function automatic logic [5:0] exp_flags(input logic [2:0] st);
    return {(st == ST_PRE) || (st == ST_INTER) || (st == ST_POST),
            (st == ST_DATA) || (st == ST_CRC),
            (st == ST_INTER), (st == ST_CRC), (st != ST_IDLE),
            (st == ST_DATA) || (st == ST_CRC)};
  endfunction

  function automatic logic [17:0] expect_vec(input rec_t r);
    return {r.st, exp_flags(r.st), r.bc, r.err};
  endfunction

  // One segment = n cycles in state st; the decisive inputs appear on its last cycle only.
  task automatic seg(input logic [2:0] st, input int n, input logic [5:0] fin_done,
                     input logic fin_wr, input logic fin_inter, input logic crc);
    for (int k = 0; k < n; k++) begin
      rec_t r;
      r.st    = st;
      r.bc    = m_bc;
      r.err   = m_err;
      r.crc   = (st == ST_DATA) ? crc : 1'($urandom);
      r.bl    = 2'($urandom);
      r.inter = 1'($urandom);
      r.wr_en = 1'($urandom);
      r.done  = 6'($urandom) & 6'($urandom) & ~relevant(st);
      if (st == ST_IDLE) r.wr_en = 1'b0;
      if (k == n - 1) begin
        r.done  = r.done | fin_done;
        r.inter = fin_inter;
        if (st == ST_IDLE || st == ST_POST) r.wr_en = fin_wr;
      end
      plan.push_back(r);
    end
  endtask

  task automatic start(input int n);  seg(ST_IDLE, n, 6'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic tail(input int n);   seg(ST_IDLE, n, 6'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic pre(input int n);    seg(ST_PRE, n, D_PRE, 1'b0, 1'b0, 1'b0); endtask
  task automatic inter(input int n);  seg(ST_INTER, n, D_INT, 1'b0, 1'b0, 1'b0); endtask
  task automatic post(input int n, input logic nxt); seg(ST_POST, n, D_POST, nxt, 1'b0, 1'b0); endtask

  task automatic body(input int dn, input logic crc, input int cn, input logic ia);
    logic [5:0] fin;
    case ($urandom_range(0, 2))
      0:       fin = D_WR;
      1:       fin = D_MASK;
      default: fin = D_WR | D_MASK;
    endcase
    if (crc) fin = D_WR;
    seg(ST_DATA, dn, fin, 1'b0, ia, crc);
    if (crc) seg(ST_CRC, cn, D_CRC, 1'b0, ia, 1'b1);
    m_bc = m_bc + 8'd1;
  endtask

  task automatic drive(input rec_t r);
    bus_main.wr_en_i = r.wr_en;            bus_wd.wr_en_i = r.wr_en;
    bus_main.burstlength_i = r.bl;         bus_wd.burstlength_i = r.bl;
    bus_main.crc_generate_i = r.crc;       bus_wd.crc_generate_i = r.crc;
    bus_main.interamble_i = r.inter;       bus_wd.interamble_i = r.inter;
    bus_main.preamble_done_i = r.done[0];  bus_wd.preamble_done_i = r.done[0];
    bus_main.wrdata_done_i = r.done[1];    bus_wd.wrdata_done_i = r.done[1];
    bus_main.wrmask_done_i = r.done[2];    bus_wd.wrmask_done_i = r.done[2];
    bus_main.wrdata_crc_done_i = r.done[3]; bus_wd.wrdata_crc_done_i = r.done[3];
    bus_main.interamble_done_i = r.done[4]; bus_wd.interamble_done_i = r.done[4];
    bus_main.postamble_done_i = r.done[5]; bus_wd.postamble_done_i = r.done[5];
  endtask

  function automatic logic [17:0] grab(input bit use_wd);
    if (use_wd)
      return {bus_wd.state_o, bus_wd.preamble_state_o, bus_wd.data_state_o,
              bus_wd.interamble_valid_o, bus_wd.crc_state_o, bus_wd.dqs_oe_o,
              bus_wd.dq_oe_o, bus_wd.burst_count_o, bus_wd.err_o};
    return {bus_main.state_o, bus_main.preamble_state_o, bus_main.data_state_o,
            bus_main.interamble_valid_o, bus_main.crc_state_o, bus_main.dqs_oe_o,
            bus_main.dq_oe_o, bus_main.burst_count_o, bus_main.err_o};
  endfunction

  // Outputs sampled at each falling edge, then that cycle's inputs are applied.
  task automatic play(input bit use_wd);
    obs.delete();
    foreach (plan[i]) begin
      @(negedge clk_i);
      obs.push_back(grab(use_wd));
      drive(plan[i]);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    drive('0);
    @(negedge clk_i);
    rst_i = 1'b0;
    m_bc  = 8'd0;
    m_err = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] exp;
    drive('0);
    #12;
    n_cmp++;
    if (grab(0) !== 18'd0) begin n_bad++; $display("FAIL reset_main: got %h want %h", grab(0), 18'd0); end
    n_cmp++;
    if (grab(1) !== 18'd0) begin n_bad++; $display("FAIL reset_wd: got %h want %h", grab(1), 18'd0); end
    @(negedge clk_i);
    rst_i = 1'b0;
    plan.delete();
    tail(4);
    play(0);
    foreach (plan[i]) begin
      exp = expect_vec(plan[i]);
      n_cmp++;
      if (obs[i] !== exp) begin n_bad++; $display("FAIL reset_idle cyc %0d: got %h want %h", i, obs[i], exp); end
    end
  endtask

  task automatic test_single_bl16();
    logic [17:0] exp;
    plan.delete();
    start(1); pre(5); body(8, 1'b0, 0, 1'b0); post(2, 1'b0); tail(3);
    play(0);
    foreach (plan[i]) begin
      exp = expect_vec(plan[i]);
      n_cmp++;
      if (obs[i] !== exp) begin n_bad++; $display("FAIL single_bl16 cyc %0d: got %h want %h", i, obs[i], exp); end
    end
  endtask

  task automatic test_crc();
    logic [17:0] exp;
    plan.delete();
    start(1); pre(5); body(8, 1'b1, 2, 1'b0); post(2, 1'b0); tail(3);
    play(0);
    foreach (plan[i]) begin
      exp = expect_vec(plan[i]);
      n_cmp++;
      if (obs[i] !== exp) begin n_bad++; $display("FAIL crc_path cyc %0d: got %h want %h", i, obs[i], exp); end
    end
  endtask

  task automatic test_interamble_chain();
    logic [17:0] exp;
    plan.delete();
    start(2); pre(3);
    body(4, 1'b0, 0, 1'b1); inter(2);
    body(3, 1'b1, 2, 1'b1); inter(3);
    body(5, 1'b0, 0, 1'b0); post(2, 1'b0); tail(3);
    play(0);
    foreach (plan[i]) begin
      exp = expect_vec(plan[i]);
      n_cmp++;
      if (obs[i] !== exp) begin n_bad++; $display("FAIL interamble cyc %0d: got %h want %h", i, obs[i], exp); end
    end
  endtask

  task automatic test_post_to_pre();
    logic [17:0] exp;
    plan.delete();
    start(1); pre(2); body(3, 1'b0, 0, 1'b0); post(1, 1'b1);
    pre(4); body(2, 1'b1, 1, 1'b0); post(3, 1'b0); tail(2);
    play(0);
    foreach (plan[i]) begin
      exp = expect_vec(plan[i]);
      n_cmp++;
      if (obs[i] !== exp) begin n_bad++; $display("FAIL post_to_pre cyc %0d: got %h want %h", i, obs[i], exp); end
    end
  endtask

  task automatic test_random();
    logic [17:0] exp;
    int nb;
    logic ia;
    plan.delete();
    for (int t = 0; t < 25; t++) begin
      start($urandom_range(1, 4));
      pre($urandom_range(1, 12));
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        ia = (b < nb - 1) ? 1'($urandom) : 1'b0;
        body($urandom_range(1, 12), 1'($urandom), $urandom_range(1, 6), ia);
        if (ia) begin
          inter($urandom_range(1, 6));
        end else if (b < nb - 1) begin
          post($urandom_range(1, 4), 1'b1);
          pre($urandom_range(1, 12));
        end else begin
          post($urandom_range(1, 4), 1'b0);
        end
      end
      tail($urandom_range(1, 3));
    end
    play(0);
    foreach (plan[i]) begin
      exp = expect_vec(plan[i]);
      n_cmp++;
      if (obs[i] !== exp) begin n_bad++; $display("FAIL random cyc %0d: got %h want %h", i, obs[i], exp); end
    end
  endtask

  task automatic test_watchdog();
    logic [17:0] exp;
    pulse_reset();
    plan.delete();
    // Nine cycles in PREAMBLE; the done flag on the ninth loses against the abort.
    start(1);
    seg(ST_PRE, 9, D_PRE, 1'b0, 1'b0, 1'b0);
    m_err = 1'b1;
    start(3); pre(8); body(5, 1'b1, 3, 1'b0); post(2, 1'b0); tail(3);
    play(1);
    foreach (plan[i]) begin
      exp = expect_vec(plan[i]);
      n_cmp++;
      if (obs[i] !== exp) begin n_bad++; $display("FAIL watchdog cyc %0d: got %h want %h", i, obs[i], exp); end
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if (bus_wd.err_o !== 1'b0) begin n_bad++; $display("FAIL watchdog_err_clear: got %b want 0", bus_wd.err_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    m_bc  = 8'd0;
    m_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [17:0] exp;
    pulse_reset();
    plan.delete();
    start(1); pre(2); body(3, 1'b0, 0, 1'b0); post(1, 1'b1); pre(2);
    seg(ST_DATA, 4, 6'b0, 1'b0, 1'b0, 1'b0);
    play(0);
    foreach (plan[i]) begin
      exp = expect_vec(plan[i]);
      n_cmp++;
      if (obs[i] !== exp) begin n_bad++; $display("FAIL reset_mid_pre cyc %0d: got %h want %h", i, obs[i], exp); end
    end
    #2;
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if (grab(0) !== 18'd0) begin n_bad++; $display("FAIL reset_mid_async: got %h want %h", grab(0), 18'd0); end
    @(negedge clk_i);
    drive('0);
    rst_i = 1'b0;
    m_bc  = 8'd0;
    m_err = 1'b0;
    plan.delete();
    start(1); pre(2); body(3, 1'b1, 1, 1'b0); post(1, 1'b0); tail(2);
    play(0);
    foreach (plan[i]) begin
      exp = expect_vec(plan[i]);
      n_cmp++;
      if (obs[i] !== exp) begin n_bad++; $display("FAIL reset_mid_after cyc %0d: got %h want %h", i, obs[i], exp); end
    end
  endtask

  initial begin
    test_reset();
    test_single_bl16();
    test_crc();
    test_interamble_chain();
    test_post_to_pre();
    test_random();
    test_watchdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
